counter_monitor: RTL

- Synthesizable on-chip checker that sits at the receiving end of the 4-bit mode counter interface.
- Observes the same control inputs the counter receives (enable, mode, D) and the counter's registered outputs (Q, rco, load).
- Runs a cycle-accurate reference model, compares every cycle, and reports mismatches, a saturating error count and a checked-cycle count.
- Used beside the behavioural or synthesized counter in scoreboard benches and as a built-in self-check in gate-level runs.

---
 rtl/counter_defs.sv | 14 +
 rtl/counter_ref_model.sv | 35 +++
 rtl/counter_monitor.sv | 74 +++++++
 3 files changed

// File: rtl/counter_defs.sv
// counter_defs: shared encodings for the 4-bit mode counter and its monitor.
package counter_defs;
    localparam int Q_W = 4;
    localparam logic [1:0] MODE_UP1 = 2'b00;
    localparam logic [1:0] MODE_DN1 = 2'b01;
    localparam logic [1:0] MODE_UP3 = 2'b10;
    localparam logic [1:0] MODE_LD  = 2'b11;
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARM   = 2'b01,
        S_CHECK = 2'b10,
        S_HALT  = 2'b11
    } state_t;
endpackage

// File: rtl/counter_ref_model.sv
// counter_ref_model: registered reference of the 4-bit mode counter (Q, rco, load).
module counter_ref_model
    import counter_defs::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [1:0]     mode,
    input  logic [Q_W-1:0] D,
    output logic [Q_W-1:0] Q,
    output logic           rco,
    output logic           load
);
    logic [Q_W:0] nxt;

    // 5-bit arithmetic: bit 4 is the carry/borrow that becomes rco
    always_comb
        nxt = mode == MODE_UP1 ? {1'b0, Q} + 5'd1 :
              mode == MODE_DN1 ? {1'b0, Q} - 5'd1 :
              mode == MODE_UP3 ? {1'b0, Q} + 5'd3 : {1'b0, D};

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            Q    <= '0;
            rco  <= 1'b0;
            load <= 1'b0;
        end else if (enable) begin
            Q    <= nxt[Q_W-1:0];
            rco  <= nxt[Q_W];
            load <= mode == MODE_LD;
        end else begin
            rco  <= 1'b0;
            load <= 1'b0;
        end
endmodule

// File: rtl/counter_monitor.sv
// counter_monitor: compares a 4-bit mode counter against a reference each cycle,
// flagging mismatches and keeping saturating error and wrapping check counts.
module counter_monitor
    import counter_defs::*;
#(
    parameter int ERR_W       = 8,
    parameter int CHK_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [Q_W-1:0]   D,
    input  logic [Q_W-1:0]   Q_dut,
    input  logic             rco_dut,
    input  logic             load_dut,
    output logic [Q_W-1:0]   exp_Q,
    output logic             mismatch,
    output logic             error,
    output logic [ERR_W-1:0] err_count,
    output logic [CHK_W-1:0] chk_count,
    output logic [1:0]       state
);
    logic   exp_rco, exp_load, fail;
    state_t st;

    counter_ref_model u_ref (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .mode   (mode),
        .D      (D),
        .Q      (exp_Q),
        .rco    (exp_rco),
        .load   (exp_load)
    );

    // case-inequality so X/Z on the counter outputs counts as a failure
    assign fail  = {Q_dut, rco_dut, load_dut} !== {exp_Q, exp_rco, exp_load};
    assign state = st;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            st        <= S_IDLE;
            mismatch  <= 1'b0;
            error     <= 1'b0;
            err_count <= '0;
            chk_count <= '0;
        end else if (clear) begin
            st        <= S_ARM;
            mismatch  <= 1'b0;
            error     <= 1'b0;
            err_count <= '0;
            chk_count <= '0;
        end else begin
            mismatch <= 1'b0;
            if (st == S_IDLE)
                st <= S_ARM;
            else if (st == S_ARM)
                st <= S_CHECK;
            else if (st == S_CHECK) begin
                chk_count <= chk_count + CHK_W'(1);
                if (fail) begin
                    mismatch  <= 1'b1;
                    error     <= 1'b1;
                    err_count <= (&err_count) ? err_count : err_count + ERR_W'(1);
                    if (STOP_ON_ERR)
                        st <= S_HALT;
                end
            end
        end
endmodule
